// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and control-bundle types for ctrl_pipe_unit and its decoder.
package ctrl_pipe_pkg;
  localparam int ALU_W = 4;
  localparam int REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                         F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22,
                         F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                         F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;

  typedef enum logic [ALU_W-1:0] {
    ALU_NOP = 4'h0, ALU_ADD = 4'h1, ALU_SUB = 4'h2, ALU_AND = 4'h3,
    ALU_OR  = 4'h4, ALU_XOR = 4'h5, ALU_NOR = 4'h6, ALU_SLT = 4'h7,
    ALU_SLL = 4'h8, ALU_SRL = 4'h9, ALU_SRA = 4'hA, ALU_LUI = 4'hB
  } alu_op_e;

  localparam logic [1:0] FWD_RF = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWB = 2'd2;

  // ID/EX contents; a bubble is the all-zero value
  typedef struct packed {
    logic             valid;
    alu_op_e          alu;
    logic             alu_src;
    logic             shift_src;
    logic             imm_zext;
    logic             branch;
    logic             branch_ne;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_t;

  typedef struct packed {
    ex_t  ex;
    logic use_rs;
    logic use_rt;
  } ctrl_t;

  typedef struct packed {
    logic             valid;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] dst;
  } mem_t;

  localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational ID decode: instruction word -> control bundle plus illegal flag.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [31:0]       instruction,
  output logic [CTRL_W-1:0] ctrl_bits,
  output logic              illegal
);
  logic [5:0]       op, funct;
  logic [REG_W-1:0] rs, rt, rd;
  logic             unused_shamt;
  ctrl_t            c;

  assign op           = instruction[31:26];
  assign rs           = instruction[25:21];
  assign rt           = instruction[20:16];
  assign rd           = instruction[15:11];
  assign funct        = instruction[5:0];
  assign unused_shamt = ^instruction[10:6];

  always_comb begin
    c          = '0;
    illegal    = 1'b0;
    c.ex.valid = 1'b1;
    c.ex.rs    = rs;
    c.ex.rt    = rt;
    case (op)
      OP_RTYPE: begin
        c.ex.dst       = rd;
        c.ex.reg_write = 1'b1;
        c.use_rt       = 1'b1;
        case (funct)
          F_ADD, F_ADDU: c.ex.alu = ALU_ADD;
          F_SUB, F_SUBU: c.ex.alu = ALU_SUB;
          F_AND:         c.ex.alu = ALU_AND;
          F_OR:          c.ex.alu = ALU_OR;
          F_XOR:         c.ex.alu = ALU_XOR;
          F_NOR:         c.ex.alu = ALU_NOR;
          F_SLT:         c.ex.alu = ALU_SLT;
          F_SLLV:        c.ex.alu = ALU_SLL;
          F_SRLV:        c.ex.alu = ALU_SRL;
          F_SRAV:        c.ex.alu = ALU_SRA;
          F_SLL: begin c.ex.alu = ALU_SLL; c.ex.shift_src = 1'b1; end
          F_SRL: begin c.ex.alu = ALU_SRL; c.ex.shift_src = 1'b1; end
          F_SRA: begin c.ex.alu = ALU_SRA; c.ex.shift_src = 1'b1; end
          default:       illegal = 1'b1;
        endcase
        // shamt shifts take operand A from the instruction, so rs is not read
        c.use_rs = ~c.ex.shift_src;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.ex.alu_src   = 1'b1;
        c.ex.dst       = rt;
        c.ex.reg_write = 1'b1;
        c.use_rs       = 1'b1;
        case (op)
          OP_SLTI: c.ex.alu = ALU_SLT;
          OP_ANDI: begin c.ex.alu = ALU_AND; c.ex.imm_zext = 1'b1; end
          OP_ORI:  begin c.ex.alu = ALU_OR;  c.ex.imm_zext = 1'b1; end
          OP_XORI: begin c.ex.alu = ALU_XOR; c.ex.imm_zext = 1'b1; end
          OP_LUI:  begin c.ex.alu = ALU_LUI; c.ex.imm_zext = 1'b1; end
          default: c.ex.alu = ALU_ADD;
        endcase
      end
      OP_LW: begin
        c.ex.alu        = ALU_ADD;
        c.ex.alu_src    = 1'b1;
        c.ex.mem_to_reg = 1'b1;
        c.ex.reg_write  = 1'b1;
        c.ex.dst        = rt;
        c.use_rs        = 1'b1;
      end
      OP_SW: begin
        c.ex.alu       = ALU_ADD;
        c.ex.alu_src   = 1'b1;
        c.ex.mem_write = 1'b1;
        c.use_rs       = 1'b1;
        c.use_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.ex.alu       = ALU_SUB;
        c.ex.branch    = 1'b1;
        c.ex.branch_ne = op[0];
        c.use_rs       = 1'b1;
        c.use_rt       = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (c.ex.dst == '0) c.ex.reg_write = 1'b0;
    if (illegal) c = '0;
  end

  assign ctrl_bits = c;
endmodule

// File: rtl/ctrl_pipe_unit.sv
// Decode + ID/EX, EX/MEM, MEM/WB control pipeline with hazard stall, flush and freeze.
// FORWARD_EN: defined -> load-use-only stalls with registered forward selects.
module ctrl_pipe_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int ALU_CTRL_W          = 4,
  parameter int REG_ADDR_W          = 5,
  parameter int RESET_ILLEGAL_CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [31:0]                    instruction,
  input  logic                           freeze,
  input  logic                           branch_taken,
  output logic                           id_ready,
  output logic                           ex_valid,
  output logic [ALU_CTRL_W-1:0]          ex_alu_control,
  output logic                           ex_alu_source,
  output logic                           ex_alu_source_shift,
  output logic                           ex_imm_zext,
  output logic                           ex_branch,
  output logic                           ex_branch_ne,
  output logic [REG_ADDR_W-1:0]          ex_rs,
  output logic [REG_ADDR_W-1:0]          ex_rt,
  output logic [1:0]                     ex_fwd_a,
  output logic [1:0]                     ex_fwd_b,
  output logic                           mem_valid,
  output logic                           mem_write,
  output logic                           mem_to_reg,
  output logic                           mem_reg_write,
  output logic [REG_ADDR_W-1:0]          mem_dst,
  output logic                           wb_valid,
  output logic                           wb_reg_write,
  output logic                           wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0]          wb_dst,
  output logic [RESET_ILLEGAL_CNT_W-1:0] illegal_cnt
);
  logic [CTRL_W-1:0]              id_bits;
  ctrl_t                          id_ctrl;
  logic                           id_illegal, hazard, load_id;
  ex_t                            idex;
  mem_t                           exmem;
  mem_t                           memwb;
  logic [RESET_ILLEGAL_CNT_W-1:0] cnt;

  ctrl_decode u_decode (
    .instruction (instruction),
    .ctrl_bits   (id_bits),
    .illegal     (id_illegal)
  );
  assign id_ctrl = ctrl_t'(id_bits);

  // reg_write is already cleared for dst 0 and for bubbles
  function automatic logic src_hit(input ctrl_t s, input logic wr, input logic [REG_W-1:0] dst);
    return wr && ((s.use_rs && s.ex.rs == dst) || (s.use_rt && s.ex.rt == dst));
  endfunction

`ifdef FORWARD_EN
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  assign hazard = id_valid && idex.mem_to_reg && src_hit(id_ctrl, idex.reg_write, idex.dst);

  // Selects describe where the operand lives once this instruction reaches EX:
  // today's ID/EX writer will be in EX/MEM, today's EX/MEM writer in MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src);
    if (used && idex.reg_write && idex.dst == src)   return FWD_EXMEM;
    if (used && exmem.reg_write && exmem.dst == src) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign fwd_a_d = fwd_sel(id_ctrl.use_rs, id_ctrl.ex.rs);
  assign fwd_b_d = fwd_sel(id_ctrl.use_rt, id_ctrl.ex.rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!freeze) begin
      fwd_a_q <= load_id ? fwd_a_d : FWD_RF;
      fwd_b_q <= load_id ? fwd_b_d : FWD_RF;
    end
  end
  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;
`else
  assign hazard = id_valid && (src_hit(id_ctrl, idex.reg_write, idex.dst) ||
                               src_hit(id_ctrl, exmem.reg_write, exmem.dst));
  assign ex_fwd_a = FWD_RF;
  assign ex_fwd_b = FWD_RF;
`endif

  // flush wins over hazard: the stalled instruction is discarded anyway
  assign id_ready = !freeze && (branch_taken || !hazard);
  assign load_id  = id_valid && !branch_taken && !hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
      cnt   <= '0;
    end else if (!freeze) begin
      idex            <= load_id ? id_ctrl.ex : '0;
      exmem.valid      <= idex.valid;
      exmem.mem_write  <= idex.mem_write;
      exmem.mem_to_reg <= idex.mem_to_reg;
      exmem.reg_write  <= idex.reg_write;
      exmem.dst        <= idex.dst;
      memwb            <= exmem;
      if (id_valid && id_illegal && !branch_taken && cnt != '1)
        cnt <= cnt + RESET_ILLEGAL_CNT_W'(1);
    end
  end

  assign ex_valid            = idex.valid;
  assign ex_alu_control      = ALU_CTRL_W'(idex.alu);
  assign ex_alu_source       = idex.alu_src;
  assign ex_alu_source_shift = idex.shift_src;
  assign ex_imm_zext         = idex.imm_zext;
  assign ex_branch           = idex.branch;
  assign ex_branch_ne        = idex.branch_ne;
  assign ex_rs               = REG_ADDR_W'(idex.rs);
  assign ex_rt               = REG_ADDR_W'(idex.rt);
  assign mem_valid           = exmem.valid;
  assign mem_write           = exmem.mem_write;
  assign mem_to_reg          = exmem.mem_to_reg;
  assign mem_reg_write       = exmem.reg_write;
  assign mem_dst             = REG_ADDR_W'(exmem.dst);
  assign wb_valid            = memwb.valid;
  assign wb_reg_write        = memwb.reg_write;
  assign wb_mem_to_reg       = memwb.mem_to_reg;
  assign wb_dst              = REG_ADDR_W'(memwb.dst);
  assign illegal_cnt         = cnt;

  logic unused_memwb_write;
  assign unused_memwb_write = memwb.mem_write;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: expected bundles queued at issue, checked per stage.
module tb_ctrl_pipe_unit;
  logic        clk = 1'b0, reset = 1'b1, id_valid = 1'b0, freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0] instruction = '0;
  logic        id_ready, ex_valid, ex_alu_source, ex_alu_source_shift, ex_imm_zext;
  logic        ex_branch, ex_branch_ne, mem_valid, mem_write, mem_to_reg, mem_reg_write;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rs, ex_rt, mem_dst, wb_dst;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [7:0]  illegal_cnt;

  ctrl_pipe_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .instruction(instruction),
    .freeze(freeze), .branch_taken(branch_taken), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_alu_control(ex_alu_control), .ex_alu_source(ex_alu_source),
    .ex_alu_source_shift(ex_alu_source_shift), .ex_imm_zext(ex_imm_zext),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dst(wb_dst), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

`ifdef FORWARD_EN
  localparam int         LU_STALLS = 1, RAW_STALLS = 0;
  localparam logic [1:0] LU_FWD = 2'd2, RAW_FWD = 2'd1;
`else
  localparam int         LU_STALLS = 2, RAW_STALLS = 2;
  localparam logic [1:0] LU_FWD = 2'd0, RAW_FWD = 2'd0;
`endif

  typedef struct {
    logic [3:0] alu;
    logic       src, sh, zx, br, bne;
    logic [4:0] rs, rt;
    logic [1:0] fa, fb;
    logic       mw, m2r, rw;
    logic [4:0] dst;
  } exp_t;

  exp_t ex_q[$], mem_q[$], wb_q[$];
  int   n_chk = 0, n_err = 0;
  bit   adv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] alu, input logic src, sh, zx, br, bne,
                              input logic [4:0] rs, rt, input logic mw, m2r, rw,
                              input logic [4:0] dst);
    exp_t e;
    e.alu = alu; e.src = src; e.sh = sh; e.zx = zx; e.br = br; e.bne = bne;
    e.rs = rs; e.rt = rt; e.fa = 2'd0; e.fb = 2'd0;
    e.mw = mw; e.m2r = m2r; e.rw = rw; e.dst = dst;
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rs, rt, rd, sa);
    return {6'h00, rs, rt, rd, sa, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // stages only move on cycles that were neither reset nor frozen
  always @(posedge clk) adv = !reset && !freeze;

  always @(negedge clk) begin
    exp_t e;
    if (adv) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected", wb_valid, 1'b0);
        else begin
          e = wb_q.pop_front();
          chk("wb_reg_write", wb_reg_write, e.rw);
          chk("wb_mem_to_reg", wb_mem_to_reg, e.m2r);
          chk("wb_dst", wb_dst, e.dst);
        end
      end
      if (mem_valid) begin
        if (mem_q.size() == 0) chk("mem_unexpected", mem_valid, 1'b0);
        else begin
          e = mem_q.pop_front();
          chk("mem_write", mem_write, e.mw);
          chk("mem_to_reg", mem_to_reg, e.m2r);
          chk("mem_reg_write", mem_reg_write, e.rw);
          chk("mem_dst", mem_dst, e.dst);
          wb_q.push_back(e);
        end
      end
      if (ex_valid) begin
        if (ex_q.size() == 0) chk("ex_unexpected", ex_valid, 1'b0);
        else begin
          e = ex_q.pop_front();
          chk("ex_alu", ex_alu_control, e.alu);
          chk("ex_src", ex_alu_source, e.src);
          chk("ex_shift", ex_alu_source_shift, e.sh);
          chk("ex_zext", ex_imm_zext, e.zx);
          chk("ex_branch", ex_branch, e.br);
          chk("ex_branch_ne", ex_branch_ne, e.bne);
          chk("ex_rs", ex_rs, e.rs);
          chk("ex_rt", ex_rt, e.rt);
          chk("ex_fwd_a", ex_fwd_a, e.fa);
          chk("ex_fwd_b", ex_fwd_b, e.fb);
          mem_q.push_back(e);
        end
      end
    end
  end

  // entered and left at posedge+1; stall cycles are counted and compared
  task automatic issue(input string tag, input logic [31:0] ins, input bit push,
                       input exp_t e, input int exp_stalls);
    int stalls = 0;
    bit done = 1'b0;
    id_valid = 1'b1;
    instruction = ins;
    while (!done) begin
      #2;
      if (id_ready) begin
        done = 1'b1;
        if (push) ex_q.push_back(e);
      end else stalls++;
      @(posedge clk);
      #1;
      if (!done && stalls >= 8) begin
        $display("FAIL %s_timeout: stalled %0d cycles, expected %0d", tag, stalls, exp_stalls);
        n_chk++;
        n_err++;
        done = 1'b1;
        stalls = -1;
      end
    end
    id_valid = 1'b0;
    if (stalls >= 0) chk({tag, "_stalls"}, stalls, exp_stalls);
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    exp_t e;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_id_ready", id_ready, 1'b1);
    chk("rst_cnt", illegal_cnt, 8'd0);
    chk("rst_alu", ex_alu_control, 4'd0);
    reset = 1'b0;
    idle(1);

    issue("add3", 32'h00221820, 1, mk(4'h1, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd3), 0);
    idle(4);

    issue("lw2", 32'h8C220000, 1, mk(4'h1, 1,0,0,0,0, 5'd1, 5'd2, 0,1,1, 5'd2), 0);
    e = mk(4'h1, 0,0,0,0,0, 5'd2, 5'd2, 0,0,1, 5'd4);
    e.fa = LU_FWD; e.fb = LU_FWD;
    issue("lu_add4", 32'h00422020, 1, e, LU_STALLS);
    idle(4);

    issue("add20", r_ins(6'h20, 5'd1, 5'd2, 5'd20, 5'd0), 1,
          mk(4'h1, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd20), 0);
    e = mk(4'h1, 0,0,0,0,0, 5'd20, 5'd1, 0,0,1, 5'd21);
    e.fa = RAW_FWD;
    issue("raw_add21", r_ins(6'h20, 5'd20, 5'd1, 5'd21, 5'd0), 1, e, RAW_STALLS);
    idle(3);

    issue("sub", r_ins(6'h22, 5'd6, 5'd7, 5'd5, 5'd0), 1,
          mk(4'h2, 0,0,0,0,0, 5'd6, 5'd7, 0,0,1, 5'd5), 0);
    issue("sll", r_ins(6'h00, 5'd5, 5'd9, 5'd8, 5'd4), 1,
          mk(4'h8, 0,1,0,0,0, 5'd5, 5'd9, 0,0,1, 5'd8), 0);
    issue("andi", i_ins(6'h0C, 5'd11, 5'd10, 16'h00FF), 1,
          mk(4'h3, 1,0,1,0,0, 5'd11, 5'd10, 0,0,1, 5'd10), 0);
    issue("lui", i_ins(6'h0F, 5'd0, 5'd12, 16'h1234), 1,
          mk(4'hB, 1,0,1,0,0, 5'd0, 5'd12, 0,0,1, 5'd12), 0);
    issue("slti", i_ins(6'h0A, 5'd14, 5'd13, 16'hFFFF), 1,
          mk(4'h7, 1,0,0,0,0, 5'd14, 5'd13, 0,0,1, 5'd13), 0);
    issue("sw", i_ins(6'h2B, 5'd16, 5'd15, 16'h0004), 1,
          mk(4'h1, 1,0,0,0,0, 5'd16, 5'd15, 1,0,0, 5'd0), 0);
    issue("beq", i_ins(6'h04, 5'd1, 5'd2, 16'h0008), 1,
          mk(4'h2, 0,0,0,1,0, 5'd1, 5'd2, 0,0,0, 5'd0), 0);
    issue("bne", i_ins(6'h05, 5'd1, 5'd1, 16'h0010), 1,
          mk(4'h2, 0,0,0,1,1, 5'd1, 5'd1, 0,0,0, 5'd0), 0);
    issue("nor", r_ins(6'h27, 5'd16, 5'd17, 5'd18, 5'd0), 1,
          mk(4'h6, 0,0,0,0,0, 5'd16, 5'd17, 0,0,1, 5'd18), 0);
    idle(4);

    issue("ill_fc", 32'hFC000000, 0, e, 0);
    #2;
    chk("ill_bubble", ex_valid, 1'b0);
    chk("ill_cnt1", illegal_cnt, 8'd1);
    #1;
    issue("ill_jr", r_ins(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), 0, e, 0);
    #2;
    chk("ill_cnt2", illegal_cnt, 8'd2);
    #1;

    issue("addi0", 32'h20200005, 1, mk(4'h1, 1,0,0,0,0, 5'd1, 5'd0, 0,0,0, 5'd0), 0);
    issue("add_r0", r_ins(6'h20, 5'd0, 5'd0, 5'd6, 5'd0), 1,
          mk(4'h1, 0,0,0,0,0, 5'd0, 5'd0, 0,0,1, 5'd6), 0);
    idle(4);

    // flush in the same cycle the load-use hazard would stall
    issue("lw7", i_ins(6'h23, 5'd1, 5'd7, 16'h0000), 1,
          mk(4'h1, 1,0,0,0,0, 5'd1, 5'd7, 0,1,1, 5'd7), 0);
    id_valid = 1'b1;
    instruction = r_ins(6'h20, 5'd7, 5'd7, 5'd8, 5'd0);
    branch_taken = 1'b1;
    #2;
    chk("br_id_ready", id_ready, 1'b1);
    @(posedge clk); #1;
    branch_taken = 1'b0;
    id_valid = 1'b0;
    #2;
    chk("br_bubble", ex_valid, 1'b0);
    #1;
    idle(4);

    issue("fz_a", r_ins(6'h20, 5'd1, 5'd2, 5'd9, 5'd0), 1,
          mk(4'h1, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd9), 0);
    issue("fz_b", r_ins(6'h22, 5'd1, 5'd2, 5'd10, 5'd0), 1,
          mk(4'h2, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd10), 0);
    issue("fz_c", r_ins(6'h26, 5'd1, 5'd2, 5'd11, 5'd0), 1,
          mk(4'h5, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd11), 0);
    freeze = 1'b1;
    id_valid = 1'b1;
    instruction = r_ins(6'h25, 5'd1, 5'd2, 5'd12, 5'd0);
    repeat (3) begin
      #2;
      chk("fz_id_ready", id_ready, 1'b0);
      chk("fz_ex_alu", ex_alu_control, 4'h5);
      chk("fz_mem_dst", mem_dst, 5'd10);
      chk("fz_wb_dst", wb_dst, 5'd9);
      chk("fz_cnt", illegal_cnt, 8'd2);
      @(posedge clk); #1;
    end
    freeze = 1'b0;
    issue("fz_d", r_ins(6'h25, 5'd1, 5'd2, 5'd12, 5'd0), 1,
          mk(4'h4, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd12), 0);
    idle(4);

    id_valid = 1'b1;
    instruction = 32'hFC000000;
    repeat (300) begin @(posedge clk); #1; end
    id_valid = 1'b0;
    #2;
    chk("ill_saturate", illegal_cnt, 8'd255);
    #1;
    idle(2);
    chk("drain_ex", ex_q.size(), 0);
    chk("drain_mem", mem_q.size(), 0);
    chk("drain_wb", wb_q.size(), 0);

    issue("rs_a", r_ins(6'h20, 5'd1, 5'd2, 5'd22, 5'd0), 1,
          mk(4'h1, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd22), 0);
    issue("rs_b", r_ins(6'h20, 5'd1, 5'd2, 5'd23, 5'd0), 1,
          mk(4'h1, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd23), 0);
    issue("rs_c", r_ins(6'h20, 5'd1, 5'd2, 5'd24, 5'd0), 1,
          mk(4'h1, 0,0,0,0,0, 5'd1, 5'd2, 0,0,1, 5'd24), 0);
    #2;
    chk("pre_rst_ex", ex_valid, 1'b1);
    chk("pre_rst_mem", mem_valid, 1'b1);
    chk("pre_rst_wb", wb_valid, 1'b1);
    #1;
    reset = 1'b1;
    @(posedge clk); #2;
    chk("rst2_ex_valid", ex_valid, 1'b0);
    chk("rst2_mem_valid", mem_valid, 1'b0);
    chk("rst2_wb_valid", wb_valid, 1'b0);
    chk("rst2_id_ready", id_ready, 1'b1);
    chk("rst2_cnt", illegal_cnt, 8'd0);
    ex_q.delete();
    mem_q.delete();
    wb_q.delete();
    #1;
    reset = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Parameterised successor to the combinational decoder. Decodes the ID-stage instruction into a control bundle and carries it through registered ID/EX, EX/MEM and MEM/WB control stages. Detects RAW/load-use hazards, inserts bubbles, and honours branch flush and external freeze. Sits between the IF/ID register and the datapath pipeline registers.

Parameters:
ALU_CTRL_W, 4, width of ALU operation code
REG_ADDR_W, 5, register-number width (5 for the MIPS regfile)
RESET_ILLEGAL_CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  instruction input holds a live instruction
instruction  in  32  ID-stage instruction word
freeze  in  1  external stall (memory busy); holds all stages
branch_taken  in  1  EX-stage branch resolved taken
id_ready  out  1  ID accepts instruction this cycle; 0 = fetch must hold
ex_valid  out  1  ID/EX holds a real instruction
ex_alu_control  out  ALU_CTRL_W  ALU op
ex_alu_source  out  1  operand B = immediate
ex_alu_source_shift  out  1  operand A = shamt
ex_imm_zext  out  1  zero-extend immediate (andi/ori/xori)
ex_branch  out  1  beq/bne
ex_branch_ne  out  1  1 = bne
ex_rs, ex_rt  out  REG_ADDR_W each  source register numbers
ex_fwd_a, ex_fwd_b  out  2 each  forward select: 0 regfile, 1 EX/MEM, 2 MEM/WB
mem_valid, mem_write, mem_to_reg, mem_reg_write  out  1 each  EX/MEM control
mem_dst  out  REG_ADDR_W  EX/MEM destination
wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control
wb_dst  out  REG_ADDR_W  MEM/WB destination
illegal_cnt  out  RESET_ILLEGAL_CNT_W  saturating count of illegal instructions

Behaviour:
- Reset: every output 0 except id_ready=1; all stage valid bits 0; illegal_cnt=0.
- Decode: R-type add/addu/sub/subu/and/or/xor/nor/slt/sll/sllv/srl/srlv/sra/srav use ALU codes 1,1,2,2,3,4,5,6,7,8,8,9,9,A,A; reg_dst=rd; shift_src for funct 0/2/3. Immediate ops are addi/addiu (1), slti (7, new), andi/ori/xori (3/4/5, zext=1), lui (B, new, zext=1); dst=rt. lw/sw use ALU op 1. beq/bne use ALU op 2, branch=1, ne=opcode[0].
- Anything else, including funct 0x08: illegal. A bubble enters ID/EX, illegal_cnt increments and saturates at all-ones.
- Destination register 0 forces reg_write=0 in the bundle.
- Bubble = valid=0 with all control bits 0.
- Latency: decode lands in ID/EX 1 cycle after acceptance. Control advances ID/EX->EX/MEM->MEM/WB one stage per non-frozen cycle.
- Priority each cycle is reset > freeze > branch_taken > hazard > normal.
- freeze=1: all stages hold, id_ready=0, illegal_cnt unchanged.
- branch_taken=1 (not frozen): ID/EX loads a bubble and the ID instruction is discarded. id_ready=1, so fetch advances to the target. EX/MEM takes the branch normally. Flush overrides a simultaneous hazard.
- Hazard: a source counts only if used (rs unless shift_src, rt for R-type/branch/sw) and nonzero. Match against valid writer destinations per the feature below.
- On a hazard, id_ready=0, a bubble enters ID/EX, and the downstream stages advance.
- The regfile writes before it reads in the same cycle, so MEM/WB is never a hazard source for ID.
- id_valid=0 loads a bubble into ID/EX and gives id_ready=1.

Optional Feature:
FORWARD_EN. Defined: stall only for load-use (ID/EX is lw and its dst matches an ID source), exactly 1 bubble. ex_fwd_a/b are registered from an EX/MEM match (priority) or a MEM/WB match against the incoming instruction's sources. Undefined: stall while an ID source matches an ID/EX or EX/MEM writer dst (up to 2 bubbles); ex_fwd_a/b tied to 0.

Decomposition:
Package ctrl_pipe_pkg holds the opcode/funct constants, ALU op codes, forward-select codes and the packed control-bundle typedef. One sub-module, ctrl_decode: the purely combinational instruction->bundle plus illegal flag. Hazard logic, stage registers and the counter stay in the top.

Test Plan:
- add $3,$1,$2 (0x00221820) then idle -> ex_alu_control=1 next cycle; mem_dst=3 a cycle later; wb_reg_write=1, wb_dst=3 a cycle after that.
- lw $2,0($1) (0x8C220000) then add $4,$2,$2 (0x00422020) -> FORWARD_EN: 1 bubble, then ex_fwd_a=ex_fwd_b=2. Without: 2 bubbles, fwd=0.
- Illegal word 0xFC000000 -> ID/EX bubble, illegal_cnt 0->1. 300 illegal words -> saturates at 255.
- addi $0,$1,5 (0x20200005) -> ex_valid=1, reg_write=0 through WB. A following add reading $0 causes no stall.
- branch_taken and a hazard in the same cycle -> bubble, id_ready=1. freeze=1 for 3 cycles mid-stream -> all stage outputs constant, id_ready=0.
- reset asserted with all three stages valid -> next cycle all valids 0, id_ready=1, illegal_cnt=0.
